// File: rtl/xyolo_read_sched.sv
// Tile scheduler for the xyolo_read weight/bias engine: programs per-tile addresses, runs the engine, throttles on consumer.
// Optional ping-pong mode enabled by defining XYOLO_READ_SCHED_PP_EN (runs PPW once per job, allows two tiles in flight).
module xyolo_read_sched #(
   parameter int CFG_ADDR_W = 6,
   parameter int IO_ADDR_W  = 32,
   parameter int TILE_W     = 16,
   parameter int W_ADDR_REG = 0,
   parameter int B_ADDR_REG = 14,
   parameter int PP_REG     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IO_ADDR_W-1:0]  w_base,
   input  logic [IO_ADDR_W-1:0]  w_stride,
   input  logic [IO_ADDR_W-1:0]  b_base,
   input  logic [IO_ADDR_W-1:0]  b_stride,
   input  logic [TILE_W-1:0]     n_tiles,
   input  logic                  cons_done,
   output logic                  cfg_valid,
   output logic [CFG_ADDR_W-1:0] cfg_addr,
   output logic [IO_ADDR_W-1:0]  cfg_wdata,
   output logic                  cfg_wstrb,
   output logic                  run,
   input  logic                  done,
   output logic                  busy,
   output logic                  job_done,
   output logic [1:0]            occ,
   output logic                  tile_ready,
   output logic                  err
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_PPW   = 4'd1;
   localparam logic [3:0] S_CFGW  = 4'd2;
   localparam logic [3:0] S_CFGB  = 4'd3;
   localparam logic [3:0] S_RUN   = 4'd4;
   localparam logic [3:0] S_BLANK = 4'd5;
   localparam logic [3:0] S_WAIT  = 4'd6;
   localparam logic [3:0] S_NEXT  = 4'd7;
   localparam logic [3:0] S_STALL = 4'd8;

`ifdef XYOLO_READ_SCHED_PP_EN
   localparam logic       PP_EN   = 1'b1;
   localparam logic [1:0] MAX_OCC = 2'd2;
`else
   localparam logic       PP_EN   = 1'b0;
   localparam logic [1:0] MAX_OCC = 2'd1;
`endif

   logic [3:0]            state, state_n;
   logic [IO_ADDR_W-1:0]  w_addr, w_n, b_addr, b_n;
   logic [IO_ADDR_W-1:0]  w_step, w_step_n, b_step, b_step_n;
   logic [TILE_W-1:0]     n_q, n_n, tile_cnt, tile_n;
   logic                  blank_cnt, blank_n;
   logic                  busy_n, job_done_n, err_n, dec_ok, inc;
   logic [1:0]            occ_n;
   logic                  cfg_valid_n;
   logic [CFG_ADDR_W-1:0] cfg_addr_n;
   logic [IO_ADDR_W-1:0]  cfg_wdata_n;

   // Next-state, address stepping and occupancy bookkeeping; outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_n     = state;
      w_n         = w_addr;
      b_n         = b_addr;
      w_step_n    = w_step;
      b_step_n    = b_step;
      n_n         = n_q;
      tile_n      = tile_cnt;
      blank_n     = blank_cnt;
      busy_n      = busy;
      job_done_n  = 1'b0;
      inc         = (state == S_NEXT);
      dec_ok      = cons_done && (occ != 2'd0);
      occ_n       = occ + {1'b0, inc} - {1'b0, dec_ok};
      err_n       = err | (cons_done && (occ == 2'd0));
      case (state)
         S_IDLE: begin
            if (start) begin
               w_n      = w_base;
               b_n      = b_base;
               w_step_n = w_stride;
               b_step_n = b_stride;
               n_n      = n_tiles;
               tile_n   = '0;
               if (n_tiles == '0) begin
                  job_done_n = 1'b1;
               end else begin
                  busy_n  = 1'b1;
                  state_n = PP_EN ? S_PPW : S_CFGW;
               end
            end
         end
         S_PPW:  state_n = S_CFGW;
         S_CFGW: state_n = S_CFGB;
         S_CFGB: state_n = S_RUN;
         S_RUN: begin
            blank_n = 1'b0;
            state_n = S_BLANK;
         end
         // The engine's done is stale until its own registered run lands, so skip two cycles.
         S_BLANK: begin
            blank_n = 1'b1;
            if (blank_cnt) state_n = S_WAIT;
         end
         S_WAIT: if (done) state_n = S_NEXT;
         S_NEXT: begin
            tile_n = tile_cnt + 1'b1;
            w_n    = w_addr + w_step;
            b_n    = b_addr + b_step;
            if (tile_n == n_q) begin
               job_done_n = 1'b1;
               busy_n     = 1'b0;
               state_n    = S_IDLE;
            end else if (occ_n == MAX_OCC) begin
               state_n = S_STALL;
            end else begin
               state_n = S_CFGW;
            end
         end
         S_STALL: if (occ < MAX_OCC) state_n = S_CFGW;
         default: state_n = S_IDLE;
      endcase

      cfg_valid_n = 1'b0;
      cfg_addr_n  = '0;
      cfg_wdata_n = '0;
      case (state_n)
         S_PPW: begin
            cfg_valid_n = 1'b1;
            cfg_addr_n  = CFG_ADDR_W'(PP_REG);
            cfg_wdata_n = IO_ADDR_W'(1);
         end
         S_CFGW: begin
            cfg_valid_n = 1'b1;
            cfg_addr_n  = CFG_ADDR_W'(W_ADDR_REG);
            cfg_wdata_n = w_n;
         end
         S_CFGB: begin
            cfg_valid_n = 1'b1;
            cfg_addr_n  = CFG_ADDR_W'(B_ADDR_REG);
            cfg_wdata_n = b_n;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         w_addr     <= '0;
         b_addr     <= '0;
         w_step     <= '0;
         b_step     <= '0;
         n_q        <= '0;
         tile_cnt   <= '0;
         blank_cnt  <= 1'b0;
         cfg_valid  <= 1'b0;
         cfg_addr   <= '0;
         cfg_wdata  <= '0;
         cfg_wstrb  <= 1'b0;
         run        <= 1'b0;
         busy       <= 1'b0;
         job_done   <= 1'b0;
         occ        <= 2'd0;
         tile_ready <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         w_addr     <= w_n;
         b_addr     <= b_n;
         w_step     <= w_step_n;
         b_step     <= b_step_n;
         n_q        <= n_n;
         tile_cnt   <= tile_n;
         blank_cnt  <= blank_n;
         cfg_valid  <= cfg_valid_n;
         cfg_addr   <= cfg_addr_n;
         cfg_wdata  <= cfg_wdata_n;
         cfg_wstrb  <= cfg_valid_n;
         run        <= (state_n == S_RUN);
         busy       <= busy_n;
         job_done   <= job_done_n;
         occ        <= occ_n;
         tile_ready <= (occ_n != 2'd0);
         err        <= err_n;
      end
   end

endmodule
